// File: rtl/oled_spi_if.sv
// Serial link between the PmodOLED controller (master) and a display endpoint (slave).
// CS is active-low, SCLK idles high, SDIN is MSB first, DC=1 marks a data byte.
interface oled_spi_if;
  logic CS;
  logic SDIN;
  logic SCLK;
  logic DC;

  modport master (output CS, output SDIN, output SCLK, output DC);
  modport slave  (input CS, input SDIN, input SCLK, input DC);
endinterface

// File: rtl/oled_spi_sink.sv
// SSD1306-style receive endpoint: deserializes the OLED link, decodes the command subset, writes a 4x128 frame buffer.
// Define OLED_SINK_HADDR_EN to decode 0x20/0x21/0x22 (horizontal addressing); otherwise those are consumed and ignored.
module oled_spi_sink #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  oled_spi_if.slave   spi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        fb_we,
  output logic [8:0]  fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        disp_on,
  output logic        chg_pump,
  output logic [15:0] cmd_cnt,
  output logic        frame_done
);
`ifdef OLED_SINK_HADDR_EN
  localparam bit HADDR_EN = 1'b1;
`else
  localparam bit HADDR_EN = 1'b0;
`endif

  localparam logic [1:0] S_CMD  = 2'd0;
  localparam logic [1:0] S_ARG1 = 2'd1;
  localparam logic [1:0] S_ARG2 = 2'd2;

  // synchronizer lanes {cs, sclk, sdin, dc}; reset to an idle link (CS and SCLK high)
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];

  logic       sclk_prev_q, sclk_prev_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [1:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [6:0] arg_hold_q, arg_hold_d;
  logic [1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic       hmode_q, hmode_d;

  logic        byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d;
  logic [7:0]  byte_data_q, byte_data_d, fb_wdata_q, fb_wdata_d;
  logic        fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [8:0]  fb_addr_q, fb_addr_d;
  logic        disp_on_q, disp_on_d, chg_pump_q, chg_pump_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d;

  logic       cs_s, sclk_s, sdin_s, dc_s;
  logic       sclk_rise, take_bit, byte_done;
  logic [7:0] rx_byte;

  assign {cs_s, sclk_s, sdin_s, dc_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // the 8th rise still completes when CS rises in the same synchronized cycle
  assign take_bit  = sclk_rise & (~cs_s | (bitcnt_q == 3'd7));
  assign byte_done = take_bit & (bitcnt_q == 3'd7);
  assign rx_byte   = {sr_q, sdin_s};

  always_comb begin
    sync_d[0] = {spi.CS, spi.SCLK, spi.SDIN, spi.DC};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    sclk_prev_d  = sclk_s;
    sr_d         = sr_q;
    bitcnt_d     = bitcnt_q;
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_hold_d   = arg_hold_q;
    page_d       = page_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    hmode_d      = hmode_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    frame_done_d = 1'b0;
    disp_on_d    = disp_on_q;
    chg_pump_d   = chg_pump_q;
    cmd_cnt_d    = cmd_cnt_q;

    if (take_bit) begin
      sr_d     = rx_byte[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
    end else if (cs_s) begin
      bitcnt_d = 3'd0;
    end

    if (byte_done) begin
      byte_valid_d = 1'b1;
      byte_data_d  = rx_byte;
      byte_dc_d    = dc_s;
      if (dc_s) begin
        // data always writes; a pending argument sequence is dropped
        state_d      = S_CMD;
        fb_we_d      = 1'b1;
        fb_addr_d    = {page_q, col_q};
        fb_wdata_d   = rx_byte;
        frame_done_d = (page_q == 2'd3) && (col_q == 7'd127);
        if (hmode_q && (col_q == col_end_q)) begin
          col_d  = col_start_q;
          page_d = (page_q == page_end_q) ? page_start_q : page_q + 2'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end else begin
        if (cmd_cnt_q != 16'hFFFF) cmd_cnt_d = cmd_cnt_q + 16'd1;
        case (state_q)
          S_CMD: begin
            cmd_d = rx_byte;
            if (rx_byte == 8'hAF) disp_on_d = 1'b1;
            else if (rx_byte == 8'hAE) disp_on_d = 1'b0;
            else if (rx_byte[7:2] == 6'b1011_00) page_d = rx_byte[1:0];
            else if (rx_byte[7:4] == 4'h0) col_d[3:0] = rx_byte[3:0];
            else if (rx_byte[7:3] == 5'b0001_0) col_d[6:4] = rx_byte[2:0];
            else begin
              case (rx_byte)
                8'h8D, 8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB,
                8'h20, 8'h21, 8'h22: state_d = S_ARG1;
                default: state_d = S_CMD;
              endcase
            end
          end
          S_ARG1: begin
            state_d    = S_CMD;
            arg_hold_d = rx_byte[6:0];
            if (cmd_q == 8'h8D) chg_pump_d = rx_byte[2];
            else if (HADDR_EN && (cmd_q == 8'h20)) hmode_d = (rx_byte[1:0] == 2'b00);
            if ((cmd_q == 8'h21) || (cmd_q == 8'h22)) state_d = S_ARG2;
          end
          S_ARG2: begin
            state_d = S_CMD;
            if (HADDR_EN && (cmd_q == 8'h21)) begin
              col_start_d = arg_hold_q;
              col_end_d   = rx_byte[6:0];
              col_d       = arg_hold_q;
            end else if (HADDR_EN && (cmd_q == 8'h22)) begin
              page_start_d = arg_hold_q[1:0];
              page_end_d   = rx_byte[1:0];
              page_d       = arg_hold_q[1:0];
            end
          end
          default: state_d = S_CMD;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1100;
      sclk_prev_q  <= 1'b1;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      state_q      <= S_CMD;
      cmd_q        <= '0;
      arg_hold_q   <= '0;
      page_q       <= '0;
      col_q        <= '0;
      page_start_q <= 2'd0;
      page_end_q   <= 2'd3;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      hmode_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      frame_done_q <= 1'b0;
      disp_on_q    <= 1'b0;
      chg_pump_q   <= 1'b0;
      cmd_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      sclk_prev_q  <= sclk_prev_d;
      sr_q         <= sr_d;
      bitcnt_q     <= bitcnt_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_hold_q   <= arg_hold_d;
      page_q       <= page_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      hmode_q      <= hmode_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      frame_done_q <= frame_done_d;
      disp_on_q    <= disp_on_d;
      chg_pump_q   <= chg_pump_d;
      cmd_cnt_q    <= cmd_cnt_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_done = frame_done_q;
  assign disp_on    = disp_on_q;
  assign chg_pump   = chg_pump_q;
  assign cmd_cnt    = cmd_cnt_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink: drives the serial link and checks every received byte against a byte-level display model.
// Build with OLED_SINK_HADDR_EN defined to exercise the horizontal-addressing frame.
module tb_oled_spi_sink;
`ifdef OLED_SINK_HADDR_EN
  localparam bit HADDR = 1'b1;
`else
  localparam bit HADDR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        byte_valid, byte_dc, fb_we, disp_on, chg_pump, frame_done;
  logic [7:0]  byte_data, fb_wdata;
  logic [8:0]  fb_addr;
  logic [15:0] cmd_cnt;
  int total = 0;
  int bad = 0;
  int bv_cnt = 0;

  oled_spi_if spi();

  oled_spi_sink #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .spi(spi),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .disp_on(disp_on), .chg_pump(chg_pump), .cmd_cnt(cmd_cnt), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (byte_valid) bv_cnt++;

  wire [46:0] all_outs = {byte_valid, byte_data, byte_dc, fb_we, fb_addr, fb_wdata,
                          disp_on, chg_pump, cmd_cnt, frame_done};

  // display model: what a display would hold after each byte, tracked at byte granularity
  logic [1:0] m_page, m_pstart, m_pend;
  logic [6:0] m_col, m_cstart, m_cend;
  logic [7:0] m_cmd, m_arg0, m_wdata;
  logic [8:0] m_addr;
  bit         m_hmode, m_disp, m_chg;
  int         m_cnt, m_args_left;

  task automatic model_reset();
    m_page = 0; m_pstart = 0; m_pend = 3;
    m_col = 0; m_cstart = 0; m_cend = 127;
    m_cmd = 0; m_arg0 = 0; m_wdata = 0; m_addr = 0;
    m_hmode = 0; m_disp = 0; m_chg = 0; m_cnt = 0; m_args_left = 0;
  endtask

  // expected layout: {data, dc, we, addr, wdata, frame_done, disp_on, chg_pump, cmd_cnt, pulse_next_cycle}
  task automatic model_byte(input bit dc, input logic [7:0] b, output logic [46:0] e);
    bit fd = 1'b0;
    if (dc) begin
      m_addr = {m_page, m_col};
      m_wdata = b;
      fd = (m_addr == 9'h1FF);
      m_args_left = 0;
      if (m_hmode && m_col == m_cend) begin
        m_col = m_cstart;
        m_page = (m_page == m_pend) ? m_pstart : m_page + 2'd1;
      end else m_col = m_col + 7'd1;
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (m_args_left == 0) begin
        m_cmd = b;
        if (b == 8'hAF) m_disp = 1;
        else if (b == 8'hAE) m_disp = 0;
        else if (b >= 8'hB0 && b <= 8'hB3) m_page = b[1:0];
        else if (b <= 8'h0F) m_col = {m_col[6:4], b[3:0]};
        else if (b >= 8'h10 && b <= 8'h17) m_col = {b[2:0], m_col[3:0]};
        else if (b inside {8'h8D, 8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20}) m_args_left = 1;
        else if (b inside {8'h21, 8'h22}) m_args_left = 2;
      end else begin
        m_args_left--;
        if (m_args_left == 1) m_arg0 = b;
        else if (m_cmd == 8'h8D) m_chg = b[2];
        else if (HADDR && m_cmd == 8'h20) m_hmode = (b[1:0] == 2'b00);
        else if (HADDR && m_cmd == 8'h21) begin
          m_cstart = m_arg0[6:0]; m_cend = b[6:0]; m_col = m_cstart;
        end else if (HADDR && m_cmd == 8'h22) begin
          m_pstart = m_arg0[1:0]; m_pend = b[1:0]; m_page = m_pstart;
        end
      end
    end
    e = {b, dc, dc, m_addr, m_wdata, fd, m_disp, m_chg, m_cnt[15:0], 1'b0};
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1; spi.CS = 1; spi.SCLK = 1; spi.SDIN = 0; spi.DC = 0;
    repeat (3) @(negedge CLK);
    RST = 0;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  task automatic set_cs(input bit v);
    @(negedge CLK);
    spi.CS = v;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_bits(input int n, input logic [7:0] b);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge CLK); spi.SCLK = 0; spi.SDIN = b[i];
      repeat (4) @(negedge CLK);
      spi.SCLK = 1;
      repeat (3) @(negedge CLK);
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b, input bit cs_last,
                           output bit got, output logic [46:0] o);
    spi.DC = dc; got = 0; o = '0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge CLK); spi.SCLK = 0; spi.SDIN = b[i];
      repeat (4) @(negedge CLK);
      spi.SCLK = 1;
      if (i == 0 && cs_last) spi.CS = 1;
      if (i != 0) repeat (3) @(negedge CLK);
    end
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge CLK);
      if (byte_valid) begin
        got = 1;
        o = {byte_data, byte_dc, fb_we, fb_addr, fb_wdata, frame_done, disp_on, chg_pump, cmd_cnt, 1'b0};
      end
    end
    @(negedge CLK);
    o[0] = byte_valid | fb_we | frame_done;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1; spi.CS = 1; spi.SCLK = 1; spi.SDIN = 0; spi.DC = 0;
    repeat (3) @(negedge CLK);
    total++;
    if (all_outs !== 47'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    RST = 0;
    model_reset();
    repeat (4) @(negedge CLK);
    total++;
    if (all_outs !== 47'd0) begin bad++; $display("FAIL idle_after_reset got=%h want=0", all_outs); end
  endtask

  task automatic test_single_cmd();
    bit got; logic [46:0] o, e;
    apply_reset();
    set_cs(0);
    send_byte(0, 8'hAF, 0, got, o);
    model_byte(0, 8'hAF, e);
    set_cs(1);
    total++;
    if (!got || o !== e) begin bad++; $display("FAIL single_cmd got=%0b obs=%h exp=%h", got, o, e); end
    total++;
    if (o[18] !== 1'b1 || o[16:1] !== 16'd1) begin
      bad++; $display("FAIL single_cmd_state disp_on=%0b cmd_cnt=%0d want 1/1", o[18], o[16:1]);
    end
  endtask

  task automatic test_page_wrap();
    bit got; logic [46:0] o, e;
    logic [8:0] want_addr [3] = '{9'h17E, 9'h17F, 9'h100};
    logic [7:0] cmds [3] = '{8'hB2, 8'h0E, 8'h17};
    logic [7:0] dats [3] = '{8'h3C, 8'h42, 8'h81};
    apply_reset();
    set_cs(0);
    for (int i = 0; i < 6; i++) begin
      bit dc = (i >= 3);
      logic [7:0] b = dc ? dats[i-3] : cmds[i];
      send_byte(dc, b, 0, got, o);
      model_byte(dc, b, e);
      total++;
      if (!got || o !== e) begin bad++; $display("FAIL page_wrap[%0d] got=%0b obs=%h exp=%h", i, got, o, e); end
      if (dc) begin
        total++;
        if (o[36:28] !== want_addr[i-3] || o[27:20] !== b) begin
          bad++; $display("FAIL page_wrap_addr[%0d] addr=%h data=%h want %h/%h", i, o[36:28], o[27:20], want_addr[i-3], b);
        end
      end
    end
    set_cs(1);
  endtask

  task automatic test_abort();
    bit got; logic [46:0] o, e;
    int start;
    set_cs(0);
    send_byte(0, 8'hAF, 0, got, o);
    model_byte(0, 8'hAF, e);
    start = bv_cnt;
    send_bits(5, 8'hFF);
    set_cs(1);
    repeat (6) @(negedge CLK);
    set_cs(0);
    send_byte(0, 8'hAE, 0, got, o);
    model_byte(0, 8'hAE, e);
    set_cs(1);
    total++;
    if (bv_cnt - start !== 1) begin bad++; $display("FAIL abort_pulses got=%0d want=1", bv_cnt - start); end
    total++;
    if (!got || o !== e) begin bad++; $display("FAIL abort_byte got=%0b obs=%h exp=%h", got, o, e); end
    total++;
    if (o[46:39] !== 8'hAE || disp_on !== 1'b0) begin
      bad++; $display("FAIL abort_decode data=%h disp_on=%0b want AE/0", o[46:39], disp_on);
    end
  endtask

  task automatic test_chg_pump();
    bit got; logic [46:0] o, e;
    apply_reset();
    set_cs(0);
    send_byte(0, 8'h8D, 0, got, o); model_byte(0, 8'h8D, e);
    send_byte(0, 8'h14, 0, got, o); model_byte(0, 8'h14, e);
    total++;
    if (!got || o !== e) begin bad++; $display("FAIL chg_pump_arg got=%0b obs=%h exp=%h", got, o, e); end
    total++;
    if (chg_pump !== 1'b1 || cmd_cnt !== 16'd2) begin
      bad++; $display("FAIL chg_pump_state chg=%0b cnt=%0d want 1/2", chg_pump, cmd_cnt);
    end
    send_byte(1, 8'h55, 0, got, o); model_byte(1, 8'h55, e);
    total++;
    if (!got || o[36:28] !== 9'h000 || o !== e) begin
      bad++; $display("FAIL chg_pump_arg_not_cmd addr=%h obs=%h exp=%h", o[36:28], o, e);
    end
    set_cs(1);
  endtask

  task automatic test_cs_same_cycle();
    bit got; logic [46:0] o, e;
    set_cs(0);
    send_byte(0, 8'hB1, 1, got, o);
    model_byte(0, 8'hB1, e);
    total++;
    if (!got || o !== e) begin bad++; $display("FAIL cs_same_cycle got=%0b obs=%h exp=%h", got, o, e); end
    set_cs(0);
    send_byte(1, 8'h99, 0, got, o);
    model_byte(1, 8'h99, e);
    total++;
    if (!got || o !== e) begin bad++; $display("FAIL cs_same_cycle_next got=%0b obs=%h exp=%h", got, o, e); end
    set_cs(1);
  endtask

  task automatic test_random();
    bit got; logic [46:0] o, e;
    logic [7:0] pool [16] = '{8'hAF, 8'hAE, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h05, 8'h0F,
                              8'h13, 8'h17, 8'h8D, 8'h81, 8'h20, 8'h21, 8'h22, 8'hD5};
    apply_reset();
    set_cs(0);
    for (int i = 0; i < 80; i++) begin
      bit dc = 1'($urandom_range(0, 1));
      logic [7:0] b = 8'($urandom);
      if (!dc && $urandom_range(0, 3) != 0) b = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) begin set_cs(1); set_cs(0); end
      send_byte(dc, b, 0, got, o);
      model_byte(dc, b, e);
      total++;
      if (!got || o !== e) begin bad++; $display("FAIL random[%0d] dc=%0b b=%h got=%0b obs=%h exp=%h", i, dc, b, got, o, e); end
    end
    set_cs(1);
  endtask

  task automatic test_haddr();
    bit got; logic [46:0] o, e;
    logic [7:0] cmds [8] = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
    apply_reset();
    set_cs(0);
    for (int i = 0; i < 8; i++) begin
      send_byte(0, cmds[i], 0, got, o); model_byte(0, cmds[i], e);
      total++;
      if (!got || o !== e) begin bad++; $display("FAIL haddr_cmd[%0d] got=%0b obs=%h exp=%h", i, got, o, e); end
    end
    if (HADDR) begin
      for (int i = 0; i < 513; i++) begin
        logic [7:0] b = 8'($urandom);
        send_byte(1, b, 0, got, o); model_byte(1, b, e);
        total++;
        if (!got || o !== e || o[36:28] !== 9'(i % 512) || o[19] !== (i == 511)) begin
          bad++; $display("FAIL hframe[%0d] addr=%h fd=%0b obs=%h exp=%h", i, o[36:28], o[19], o, e);
        end
      end
    end else begin
      logic [7:0] seq [3] = '{8'hB3, 8'h0F, 8'h17};
      logic [8:0] want [3] = '{9'h1FF, 9'h180, 9'h181};
      for (int i = 0; i < 3; i++) begin
        send_byte(0, seq[i], 0, got, o); model_byte(0, seq[i], e);
      end
      for (int i = 0; i < 3; i++) begin
        logic [7:0] b = 8'($urandom);
        send_byte(1, b, 0, got, o); model_byte(1, b, e);
        total++;
        if (!got || o !== e || o[36:28] !== want[i] || o[19] !== (i == 0)) begin
          bad++; $display("FAIL page_mode_kept[%0d] addr=%h fd=%0b want %h obs=%h exp=%h", i, o[36:28], o[19], want[i], o, e);
        end
      end
    end
    set_cs(1);
  endtask

  task automatic test_reset_mid();
    bit got; logic [46:0] o, e;
    apply_reset();
    set_cs(0);
    send_byte(0, 8'hAF, 0, got, o); model_byte(0, 8'hAF, e);
    send_byte(0, 8'hB2, 0, got, o); model_byte(0, 8'hB2, e);
    send_byte(1, 8'h11, 0, got, o); model_byte(1, 8'h11, e);
    spi.DC = 1;
    send_bits(4, 8'hF0);
    @(negedge CLK);
    RST = 1;
    #1;
    total++;
    if (all_outs !== 47'd0) begin bad++; $display("FAIL reset_mid_outputs got=%h want=0", all_outs); end
    repeat (3) @(negedge CLK);
    RST = 0;
    model_reset();
    set_cs(1);
    set_cs(0);
    send_byte(1, 8'hA5, 0, got, o); model_byte(1, 8'hA5, e);
    total++;
    if (!got || o !== e || o[36:28] !== 9'h000) begin
      bad++; $display("FAIL reset_mid_next got=%0b addr=%h obs=%h exp=%h", got, o[36:28], o, e);
    end
    set_cs(1);
  endtask

  initial begin
    spi.CS = 1; spi.SCLK = 1; spi.SDIN = 0; spi.DC = 0;
    model_reset();
    test_reset();
    test_single_cmd();
    test_page_wrap();
    test_abort();
    test_chg_pump();
    test_cs_same_cycle();
    test_random();
    test_haddr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/oled_spi_sink.md
# oled_spi_sink

Receive-side model of the PmodOLED serial link: a synthesizable SSD1306-style display endpoint that deserializes the CS/SDIN/SCLK/DC stream produced by the OLED controller. It decodes the command subset the init and display sequencers emit and writes data bytes into a 4-page × 128-column frame-buffer port. It sits on the bench and in loopback builds opposite the controller, so an on-chip checker can compare displayed pages against expected content.

## Interface
- `SYNC_STAGES`, default 2: input synchronizer depth, legal 2..3.
- `CLK` input, 1 bit: system clock, at least 8× the SCLK rate.
- `RST` input, 1 bit: reset, asynchronous, active-high.
- `CS` input, 1 bit: chip select, active-low, asynchronous to CLK.
- `SDIN` input, 1 bit: serial data, MSB first, sampled on SCLK rise.
- `SCLK` input, 1 bit: serial clock, idle high.
- `DC` input, 1 bit: 0 = command byte, 1 = data byte.
- `byte_valid` output, 1 bit: one-cycle pulse per received byte.
- `byte_data` output, 8 bits: the received byte.
- `byte_dc` output, 1 bit: DC value captured with the byte.
- `fb_we` output, 1 bit: frame-buffer write strobe.
- `fb_addr` output, 9 bits: write address, {page[1:0], col[6:0]}.
- `fb_wdata` output, 8 bits: write data; bit 0 is the top pixel row of the page.
- `disp_on` output, 1 bit: display-on state.
- `chg_pump` output, 1 bit: charge-pump enable.
- `cmd_cnt` output, 16 bits: count of command bytes, saturating at 0xFFFF.
- `frame_done` output, 1 bit: pulse on a write to page 3, column 127.

## Operation
- **Synchronization:** CS, SDIN, SCLK and DC each pass through `SYNC_STAGES` flops. An SCLK rising edge is detected on the synchronized copy.
- **Shift:** On each detected SCLK rise with synchronized CS=0, shift SDIN into `sr[7:0]` and increment `bitcnt`.
- **Byte complete:** On the 8th bit, capture DC and pulse `byte_valid` with `byte_data` and `byte_dc`. Then clear `bitcnt`.
- **Abort:** Synchronized CS=1 clears `bitcnt` and drops any partial byte. No pulse is produced.
- **Command FSM** (acts on command bytes only):
  - `S_CMD` to `S_ARG1` on commands that take arguments.
  - `S_ARG1` goes to `S_ARG2` for two-argument commands, otherwise back to `S_CMD`.
  - `S_ARG2` returns to `S_CMD`.
  - Reset state is `S_CMD`.
- **Decoded in `S_CMD`:**
  - 0xAF sets `disp_on`; 0xAE clears it.
  - 0xB0–0xB3 sets page to `[1:0]`.
  - 0x00–0x0F sets col[3:0].
  - 0x10–0x17 sets col[6:4].
  - 0x8D takes 1 argument; `chg_pump` takes arg bit 2.
- **Consumed and ignored:**
  - 1-argument commands: 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB.
  - All other commands with no argument.
- **Command counter:** Every command byte, including argument bytes, increments `cmd_cnt`.
- **Data bytes:** Drive `fb_we`=1, `fb_addr`={page,col}, `fb_wdata`=byte, then advance col.
  - Page mode: col wraps 127→0 and page is unchanged.
- **Data during an argument state:** A data byte arriving in `S_ARG1` or `S_ARG2` aborts the FSM to `S_CMD`, discards the pending command, and is still written normally.
- **Reset values:**
  - All outputs 0.
  - page=0, col=0, addressing mode=page.
  - col range [0,127], page range [0,3].

## Timing
- **Byte latency:** `byte_valid` asserts on the CLK edge `SYNC_STAGES`+1 cycles after the 8th SCLK rise at the pins. With the default depth that is 3 cycles.
- **Frame-buffer write:** `fb_we`, `fb_addr` and `fb_wdata` are registered and valid in the same cycle as `byte_valid`.
- **Pulse width:** `fb_we` and `frame_done` last exactly 1 cycle.
- **Registered state:** `disp_on`, `chg_pump`, page, col and `cmd_cnt` update in that same cycle.
- **Throughput:** At most one byte per 8 SCLK periods, so there is no back-pressure and no buffering.
- **CS deassert in the completing cycle:** If CS rises in the same synchronized cycle as the 8th SCLK rise, the byte completes, because the edge is evaluated before the abort.
- **Asynchronous reset mid-byte:** Clears the shift register, `bitcnt`, the FSM and all outputs immediately. The next byte starts after RST falls and CS falls.

## Configuration
- **`OLED_SINK_HADDR_EN` defined:** Decodes three additional commands.
  - 0x20 (1 argument): arg[1:0]=00 selects horizontal mode; anything else selects page mode.
  - 0x21 (2 arguments): col_start, col_end, 7 bits each. Setting it also loads col=col_start.
  - 0x22 (2 arguments): page_start, page_end, 2 bits each. Setting it also loads page=page_start.
  - In horizontal mode, a write at col_end sets col=col_start and advances page. Page wraps from page_end to page_start.
- **Not defined:** 0x20 is consumed as a 1-argument command and 0x21/0x22 as 2-argument commands, all ignored. Addressing stays in page mode.

## Test plan
- **Single command:** Reset, then CS low, command 0xAF, CS high → `byte_valid` with `byte_data`=0xAF and `byte_dc`=0; `disp_on`=1; `cmd_cnt`=1.
- **Page-mode write with wrap:** Commands 0xB2, 0x0E, 0x17 (page 2, column 126), then data 0x3C, 0x42, 0x81 → `fb_addr` sequence 0x17E, 0x17F, 0x100, with matching `fb_wdata`.
- **Aborted partial byte:** CS high after 5 bits, then a full command 0xAE → only one `byte_valid` (0xAE); `disp_on`=0.
- **Charge-pump argument:** Command 0x8D, then argument 0x14 → `chg_pump`=1; argument 0x14 not decoded as a command; `cmd_cnt`=2.
- **Full horizontal-mode frame (macro defined):** Commands 0x20 0x00, 0x21 0x00 0x7F, 0x22 0x00 0x03, then 512 data bytes → `fb_addr` 0x000..0x1FF; `frame_done` pulses on the 512th byte. Byte 513 writes to 0x000.
- **Reset mid-operation:** RST asserted after 4 data bits → all outputs 0 within the same cycle; next full data byte writes to `fb_addr` 0x000.
